// File: rtl/mano_pkg.sv
// Shared constants and FSM state encoding for the Mano CPU memory responder.
// The responder is configured with the MANO_MEM_WAIT_EN macro.
package mano_pkg;

   localparam int MANO_AW    = 4;
   localparam int MANO_DW    = 8;
   localparam int MANO_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_e;

endpackage

// File: rtl/mano_mem_array.sv
// Register-file memory: one write port shared by CPU and loader, one
// combinational read port, asynchronous clear of every word.
module mano_mem_array
   import mano_pkg::*;
#(
   parameter int DW = MANO_DW,
   parameter int AW = MANO_AW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_data_i,
   input  logic          ld_we_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [DW-1:0] ld_data_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   // Loader wins the shared port; the FSM never issues both in one cycle.
   always_comb begin
      we    = ld_we_i | cpu_we_i;
      waddr = ld_we_i ? ld_addr_i : cpu_addr_i;
      wdata = ld_we_i ? ld_data_i : cpu_data_i;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mano_mem_responder.sv
// Memory slave for the Mano CPU with req/ack handshake and program loader.
// Define MANO_MEM_WAIT_EN to add WAIT_CYCLES wait states per access.
module mano_mem_responder
   import mano_pkg::*;
#(
   parameter int DW          = MANO_DW,
   parameter int AW          = MANO_AW,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic          ack_o,
   output logic [DW-1:0] rdata_o,
   output logic          busy_o,
   output logic          err_o,
   input  logic          ld_en_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [DW-1:0] ld_data_i
);

   state_e        state_q, state_d;
   logic          err_q, err_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [AW-1:0] acc_addr;
   logic          acc_we;
   logic [DW-1:0] acc_wdata;
   logic          enter_ack;
   logic          cpu_wr;
   logic          ld_wr;
   logic [DW-1:0] mem_rdata;

`ifdef MANO_MEM_WAIT_EN
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
`endif

   assign ld_wr = ld_en_i && (state_q == IDLE);

   always_comb begin
      state_d   = state_q;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      enter_ack = 1'b0;
      cpu_wr    = 1'b0;
      acc_addr  = addr_i;
      acc_we    = we_i;
      acc_wdata = wdata_i;
`ifdef MANO_MEM_WAIT_EN
      cnt_d = cnt_q;
      if (state_q == WAIT) begin
         acc_addr  = addr_q;
         acc_we    = we_q;
         acc_wdata = wdata_q;
      end
`endif
      unique case (state_q)
         IDLE: begin
            if (!ld_en_i && req_i) begin
`ifdef MANO_MEM_WAIT_EN
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CW'(WAIT_CYCLES - 1);
               end else begin
                  state_d   = ACK;
                  enter_ack = 1'b1;
               end
`else
               state_d   = ACK;
               enter_ack = 1'b1;
`endif
            end
         end
         WAIT: begin
`ifdef MANO_MEM_WAIT_EN
            if (!req_i) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (cnt_q == '0) begin
               state_d   = ACK;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
`else
            state_d = IDLE;
`endif
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (ld_en_i && state_q != IDLE) begin
         err_d = 1'b1;
      end
      // Memory side effects happen on the edge that enters ACK.
      if (enter_ack) begin
         cpu_wr = acc_we;
         if (!acc_we) begin
            rdata_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MANO_MEM_WAIT_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (state_q == IDLE && req_i && !ld_en_i) begin
            addr_q  <= addr_i;
            we_q    <= we_i;
            wdata_q <= wdata_i;
         end
      end
   end
`endif

   mano_mem_array #(
      .DW(DW),
      .AW(AW)
   ) u_mem (
      .CLK       (CLK),
      .RST       (RST),
      .cpu_we_i  (cpu_wr),
      .cpu_addr_i(acc_addr),
      .cpu_data_i(acc_wdata),
      .ld_we_i   (ld_wr),
      .ld_addr_i (ld_addr_i),
      .ld_data_i (ld_data_i),
      .raddr_i   (acc_addr),
      .rdata_o   (mem_rdata)
   );

   assign ack_o   = (state_q == ACK);
   assign busy_o  = (state_q != IDLE);
   assign err_o   = err_q;
   assign rdata_o = rdata_q;

endmodule

// File: doc/mano_mem_responder.md
MANO_MEM_RESPONDER -- requirements
Module: mano_mem_responder

Interface
REQ-001 Parameter DW, default 8, data word width; SHALL match the CPU DR/AC width.
REQ-002 Parameter AW, default 4, address width; SHALL match the CPU PC/AR width (16 words).
REQ-003 Parameter WAIT_CYCLES, default 2, wait states per access; used only when MANO_MEM_WAIT_EN is defined.
REQ-004 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 req_i  input  1  CPU access request; held high until ack_o.
REQ-007 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-008 addr_i  input  AW  word address.
REQ-009 wdata_i  input  DW  write data.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 rdata_o  output  DW  read data; valid while ack_o is high, held until the next ack.
REQ-012 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-013 err_o  output  1  one-cycle pulse on an aborted access.
REQ-014 ld_en_i  input  1  program-loader write strobe.
REQ-015 ld_addr_i  input  AW  loader address.
REQ-016 ld_data_i  input  DW  loader data.

Function
REQ-017 FSM states: IDLE, WAIT, ACK.
REQ-018 IDLE with req_i=1 and ld_en_i=0: capture addr_i, we_i, wdata_i; go to WAIT if the macro is defined and WAIT_CYCLES>0, else go to ACK.
REQ-019 WAIT: load a down-counter with WAIT_CYCLES-1 on entry; go to ACK when it reaches 0.
REQ-020 On the edge entering ACK: a write commits the captured data to memory; a read registers mem[addr] into rdata_o.
REQ-021 ACK: ack_o=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-022 Latency from the req_i-sampling edge to ack_o high SHALL be 1 cycle without the macro and 1+WAIT_CYCLES cycles with it.
REQ-023 req_i still high in IDLE after ACK SHALL start a new access, giving back-to-back throughput of one access per 2 cycles (no waits).
REQ-024 req_i low during WAIT SHALL abort: return to IDLE, no memory write, err_o pulses once, ack_o stays 0.
REQ-025 ld_en_i in IDLE SHALL write ld_data_i to mem[ld_addr_i] on that edge and SHALL take priority over a simultaneous req_i; the req_i is served the next cycle.
REQ-026 ld_en_i outside IDLE SHALL be ignored and SHALL pulse err_o.
REQ-027 Addresses SHALL wrap modulo 2^AW; there are no out-of-range accesses.
REQ-028 A read of an address written in the same access sequence SHALL return the new data (write-then-read coherency).

Reset
REQ-029 RST SHALL force state=IDLE, ack_o=0, err_o=0, busy_o=0, rdata_o=0, the wait counter to 0, and all memory words to 0.
REQ-030 RST asserted mid-access SHALL drop the access with no write and no ack, regardless of the clock.

Configuration
REQ-031 Macro MANO_MEM_WAIT_EN defined: the WAIT state and counter are present and WAIT_CYCLES is honoured.
REQ-032 Macro MANO_MEM_WAIT_EN undefined: no WAIT state or counter logic, fixed 1-cycle latency, WAIT_CYCLES ignored, and REQ-024 cannot occur.

Structure
REQ-033 Package mano_pkg SHALL hold MANO_AW=4, MANO_DW=8, MANO_DEPTH=16, and the state enum {IDLE, WAIT, ACK}.
REQ-034 Sub-module mano_mem_array SHALL implement the 16x8 register file: one synchronous write port muxed between CPU and loader, one read port, and async clear.

Verification
REQ-035 Loader writes 0x3C to address 5, then CPU reads address 5 -> ack_o one cycle after req_i; rdata_o=0x3C.
REQ-036 CPU writes 0xA5 to address 0xF, then reads address 0xF -> rdata_o=0xA5; address 0x0 still reads 0x00.
REQ-037 MANO_MEM_WAIT_EN with WAIT_CYCLES=2 and a read request -> ack_o high exactly 3 cycles after the sampling edge; busy_o high for 3 cycles.
REQ-038 MANO_MEM_WAIT_EN with a write of 0x11 to address 2, req_i dropped after 1 cycle -> err_o pulses, no ack_o, and address 2 still reads 0x00.
REQ-039 ld_en_i (address 3, 0x77) and a req_i read of address 3 in the same IDLE cycle -> loader wins; the read acks the following access with rdata_o=0x77.
REQ-040 RST pulsed during ACK after writing 0x99 to address 1 -> all outputs 0 and address 1 reads 0x00.
